// File: rtl/sw_debounce.sv
// Per-bit switch synchroniser + stable-time debouncer with registered rise/fall pulses.
// Optional `sw_changed` output is enabled by defining SW_DB_CHANGED_EN.
module sw_debounce #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`ifdef SW_DB_CHANGED_EN
  ,
  output logic             sw_changed
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync     [WIDTH];
  logic [CNT_W-1:0]       cnt      [WIDTH];
  logic [CNT_W-1:0]       cnt_nxt  [WIDTH];
  logic [WIDTH-1:0]       s;
  logic [WIDTH-1:0]       db_nxt;
  logic [WIDTH-1:0]       rise_nxt;
  logic [WIDTH-1:0]       fall_nxt;

  // Qualification: a bit must disagree with its debounced value for
  // STABLE_CYCLES consecutive edges; any agreeing cycle clears the count.
  always_comb begin
    s        = '0;
    db_nxt   = sw_db;
    rise_nxt = '0;
    fall_nxt = '0;
    cnt_nxt  = '{default: '0};
    for (int i = 0; i < int'(WIDTH); i++) begin
      s[i] = sync[i][SYNC_STAGES-1];
      if (s[i] != sw_db[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_nxt[i]   = s[i];
          rise_nxt[i] = s[i];
          fall_nxt[i] = ~s[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        sync[i] <= '0;
        cnt[i]  <= '0;
      end
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], sw_raw[i]};
        cnt[i]  <= cnt_nxt[i];
      end
      sw_db   <= db_nxt;
      sw_rise <= rise_nxt;
      sw_fall <= fall_nxt;
    end
  end

`ifdef SW_DB_CHANGED_EN
  // Mode-restart strobe, derived from the already registered pulses.
  assign sw_changed = |(sw_rise | sw_fall);
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: directed test-plan scenarios plus random stimulus
// checked against a run-length reference model. Honours SW_DB_CHANGED_EN.
module tb_sw_debounce;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned STABLE = 8;
  localparam int unsigned SYNC   = 2;
  localparam int          LAT    = int'(SYNC + STABLE);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
`ifdef SW_DB_CHANGED_EN
  logic             sw_changed;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sw_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
`ifdef SW_DB_CHANGED_EN
    ,
    .sw_changed(sw_changed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] raw_q[$];
  logic [WIDTH-1:0] m_db;
  logic [WIDTH-1:0] m_rise;
  logic [WIDTH-1:0] m_fall;
  int               run[WIDTH];

  // Reference model: the synchroniser is a SYNC-deep delay line of raw samples;
  // a bit flips once it has disagreed with its level for STABLE straight edges.
  always @(posedge clk) begin
    logic [WIDTH-1:0] s;
    if (rst) begin
      raw_q.delete();
      for (int k = 0; k < int'(SYNC); k++) raw_q.push_back('0);
      m_db = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < int'(WIDTH); i++) run[i] = 0;
    end else begin
      s = raw_q.pop_front();
      raw_q.push_back(sw_raw);
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        run[i] = (s[i] != m_db[i]) ? run[i] + 1 : 0;
        if (run[i] == int'(STABLE)) begin
          m_db[i]   = s[i];
          m_rise[i] = s[i];
          m_fall[i] = ~s[i];
          run[i]    = 0;
        end
      end
    end
    exp_q.push_back('{db: m_db, rise: m_rise, fall: m_fall});
  end

  // Monitor: every cycle the DUT presents a new output word; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (sw_db !== e.db || sw_rise !== e.rise || sw_fall !== e.fall) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t db=%b rise=%b fall=%b, expected db=%b rise=%b fall=%b",
                 $time, sw_db, sw_rise, sw_fall, e.db, e.rise, e.fall);
      end
`ifdef SW_DB_CHANGED_EN
      n_cmp++;
      if (sw_changed !== |(e.rise | e.fall)) begin
        n_bad++;
        $display("FAIL sw_changed t=%0t got %b expected %b", $time, sw_changed, |(e.rise | e.fall));
      end
`endif
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until a masked rise (or fall) pulse appears; -1 if the budget expires.
  task automatic wait_pulse(input logic [WIDTH-1:0] mask, input bit want_rise, output int k,
                            output logic [WIDTH-1:0] seen);
    k = -1;
    seen = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (((want_rise ? sw_rise : sw_fall) & mask) != '0) begin
        k = n;
        seen = want_rise ? sw_rise : sw_fall;
        break;
      end
    end
  endtask

  initial begin
    int               k;
    logic [WIDTH-1:0] seen;

    // Reset and hold with all switches high.
    rst = 1'b1;
    sw_raw = 4'hF;
    cyc(2);
    check("db_in_reset", int'(sw_db), 0);
    cyc(1);
    rst = 1'b0;
    wait_pulse(4'hF, 1'b1, k, seen);
    check("reset_release_latency", k, LAT);
    check("reset_release_rise", int'(seen), 'hF);
    check("reset_release_db", int'(sw_db), 'hF);
    cyc(1);
    check("rise_one_cycle", int'(sw_rise), 0);

    // Glitch shorter than the stable time.
    sw_raw = 4'h0;
    cyc(LAT + 2);
    sw_raw = 4'b0001;
    cyc(5);
    sw_raw = 4'h0;
    cyc(20);
    check("glitch_db", int'(sw_db), 0);

    // Bounce on bit 1, then a clean high.
    for (int t = 0; t < 30; t++) begin
      sw_raw[1] = ((t / 3) % 2 == 0);
      cyc(1);
    end
    sw_raw[1] = 1'b1;
    wait_pulse(4'b0010, 1'b1, k, seen);
    check("bounce_latency", k, LAT);
    check("bounce_rise", int'(seen), 'b0010);

    // Fall on bit 2.
    sw_raw = 4'b0100;
    cyc(LAT + 2);
    check("fall_setup_db", int'(sw_db), 'b0100);
    sw_raw = 4'b0000;
    wait_pulse(4'b0100, 1'b0, k, seen);
    check("fall_latency", k, LAT);
    check("fall_pulse", int'(seen), 'b0100);
    check("fall_db", int'(sw_db), 0);
`ifdef SW_DB_CHANGED_EN
    check("fall_changed", int'(sw_changed), 1);
`endif

    // Two bits qualifying on the same edge.
    cyc(LAT);
    sw_raw = 4'b1001;
    wait_pulse(4'b1001, 1'b1, k, seen);
    check("simul_latency", k, LAT);
    check("simul_rise", int'(seen), 'b1001);

    // Reset in the middle of a qualification on bit 3.
    sw_raw = 4'b0000;
    cyc(LAT + 2);
    sw_raw = 4'b1000;
    cyc(7);
    rst = 1'b1;
    cyc(2);
    check("midcount_db_in_reset", int'(sw_db), 0);
    rst = 1'b0;
    wait_pulse(4'b1000, 1'b1, k, seen);
    check("midcount_latency", k, LAT);
    check("midcount_rise", int'(seen), 'b1000);

    // Random bouncing with occasional resets.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < int'(WIDTH); i++)
        if ($urandom_range(11) == 0) sw_raw[i] = ~sw_raw[i];
      rst = ($urandom_range(299) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(LAT + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Upstream conditioning stage for the board slide switches. It feeds the switch-driven mode select that picks which LED sequence generator (cycle, lfsr, blinker, looper, cycle_v2, raw passthrough) drives `led`.
- Synchronises each asynchronous switch bit into `clk` and debounces it with a stable-time counter.
- Emits clean levels plus one-cycle rise/fall pulses, so the mode mux never sees metastable or bouncing select values.

Parameters:
- WIDTH, 4, number of switch bits handled (independent per-bit channels)
- STABLE_CYCLES, 1000000, consecutive cycles a synchronised bit must differ from its debounced value before the change is accepted (10 ms at 100 MHz); legal range >= 2
- SYNC_STAGES, 2, flip-flops in each bit's synchroniser chain; legal range >= 2

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- sw_raw  input  WIDTH  asynchronous switch inputs from pins
- sw_db  output  WIDTH  debounced, synchronised switch levels
- sw_rise  output  WIDTH  per-bit one-cycle pulse, sw_db[i] went 0->1 this cycle
- sw_fall  output  WIDTH  per-bit one-cycle pulse, sw_db[i] went 1->0 this cycle

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high. Nothing else is clocked or reset asynchronously.
- Reset values: all synchroniser flops 0, all counters 0, sw_db = 0, sw_rise = 0, sw_fall = 0. While rst is high, outputs hold these values regardless of sw_raw.
- Synchroniser: per bit, a chain of SYNC_STAGES flops; `s[i]` is the last stage. No logic between stages.
- Counter: per bit, width $clog2(STABLE_CYCLES). Each edge, not in reset:
  - if s[i] == sw_db[i]: cnt[i] <= 0
  - else if cnt[i] == STABLE_CYCLES-1: sw_db[i] <= s[i], cnt[i] <= 0
  - else: cnt[i] <= cnt[i]+1
- Latency: a raw change first sampled at edge 1 and held stable appears on sw_db at edge SYNC_STAGES+STABLE_CYCLES. Example: edge 10 for SYNC_STAGES=2, STABLE_CYCLES=8.
- Any single cycle where s[i] returns to sw_db[i] restarts the count from zero. Glitches shorter than STABLE_CYCLES synchronised cycles never propagate.
- Pulses: sw_rise and sw_fall are registered and asserted on the same edge sw_db updates. They are high exactly one cycle and never high together for the same bit.
- Bits are fully independent. Simultaneous changes on several bits that qualify on the same edge update and pulse together.
- Counter never wraps: it saturates by construction at STABLE_CYCLES-1 followed by clear.
- Reset mid-count: the count is discarded, sw_db returns to 0, and qualification restarts after reset release.

Optional Feature:
- Macro SW_DB_CHANGED_EN.
- Defined: adds output `sw_changed` (1 bit) = OR-reduction of (sw_rise | sw_fall), combinational from registered pulses, same cycle as the pulses. Reset value 0. The mode mux uses it to restart the newly selected sequence.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (bench uses STABLE_CYCLES=8, SYNC_STAGES=2):
- Reset and hold: sw_raw=4'hF, rst high 3 cycles -> sw_db=0 and pulses 0 during reset; after release sw_db=4'hF at the 10th edge, sw_rise=4'hF for exactly that one cycle.
- Glitch reject: from sw_db=0, sw_raw[0]=1 for 5 cycles then 0 -> sw_db stays 0, no pulse, for 20 cycles.
- Bounce: sw_raw[1] toggles every 3 cycles for 30 cycles, then held 1 -> sw_db[1] rises exactly 10 edges after the final transition, single sw_rise=4'b0010 pulse, no sw_fall.
- Fall: sw_db=4'b0100, sw_raw[2] -> 0 held -> sw_db=0 after 10 edges, sw_fall=4'b0100 one cycle. With SW_DB_CHANGED_EN, sw_changed=1 on the same cycle.
- Simultaneous bits: sw_raw 4'b0000 -> 4'b1001 on one edge -> both bits update on the same edge, sw_rise=4'b1001 one cycle.
- Reset mid-count: sw_raw[3]=1, assert rst when cnt[3]=5 -> sw_db=0, cnt=0. After release, sw_db[3]=1 only 10 edges later, not earlier.
